axis_rx_frame_checker: RTL and testbench
========================================

// Module: axis_rx_frame_checker
// PURPOSE
//  Receive-side counterpart of the 10G Ethernet AXIS test-frame generator. Sits on the MAC RX AXIS
//  output (no tready, MAC cannot be back-pressured). Byte-swaps each beat, checks the header and
//  counting payload of every frame, and reports per-frame status plus saturating good/bad counters.
// PARAMETERS
//  P_RECV_LEN  186                    expected beats per frame, tlast beat included (>=3)
//  P_DST_MAC   48'hff_ff_ff_ff_ff_ff  expected destination MAC
//  P_SRC_MAC   48'h01_02_03_04_05_06  expected source MAC
//  P_TYPE      16'h0800               expected EtherType
//  P_CNT_W     32                     width of frame counters
// PORTS
//  i_clk               in   1        core clock, rising edge
//  i_rst_n             in   1        asynchronous, active-low reset
//  i_stat_rx_status    in   1        MAC RX link/block-lock status
//  s_axis_rx_tvalid    in   1        beat valid; no tready, every valid beat is consumed
//  s_axis_rx_tdata     in   64       first wire byte in [7:0]
//  s_axis_rx_tlast     in   1        last beat of frame
//  s_axis_rx_tkeep     in   8        byte enables, bit0 = first byte
//  s_axis_rx_tuser     in   1        MAC bad-frame flag, meaningful on tlast beat
//  o_frame_done        out  1        1-cycle pulse per checked frame
//  o_frame_ok          out  1        valid with o_frame_done: frame had no error
//  o_err_code          out  4        valid with o_frame_done: [0] header [1] payload [2] length [3] keep/tuser
//  o_good_cnt          out  P_CNT_W  frames with o_frame_ok=1, saturating
//  o_bad_cnt           out  P_CNT_W  frames with o_frame_ok=0, saturating
//  o_first_err_beat    out  16       beat index of first mismatch since reset (macro only)
//  o_first_err_data    out  64       swapped data of that beat (macro only)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = ST_SYNC, beat counter 0, sticky error bits 0.
//  - Swap: d = byte-reverse(tdata), k = bit-reverse(tkeep); first wire byte at d[63:56].
//  - Expected beats: b0 = {P_DST_MAC, P_SRC_MAC[47:32]}; b1 = {P_SRC_MAC[31:0], P_TYPE, 16'hffff};
//    bn (2..P_RECV_LEN-1) = {4{n-1}} as 16-bit words, n-1 truncated to 16 b.
//  - FSM: ST_SYNC: discard beats until a tlast beat with status=1, then go to ST_IDLE.
//    ST_IDLE: valid beat -> check as b0, go to ST_HDR (or finish frame if tlast).
//    ST_HDR: check b1 -> ST_PAY. ST_PAY: check bn; beat P_RECV_LEN-1 must carry tlast.
//    ST_DROP: entered when beat P_RECV_LEN-1 lacks tlast; length bit set; discard until tlast.
//  - Error bits are sticky within a frame: header (b0/b1 mismatch), payload (any bn mismatch),
//    length (tlast before beat P_RECV_LEN-1 or missing there), keep/tuser (k != 8'hff on any beat,
//    or tuser=1 on tlast beat).
//  - Frame end: tlast beat sampled in IDLE/HDR/PAY/DROP -> next cycle o_frame_done=1,
//    o_err_code = accumulated bits, o_frame_ok = (code == 0), exactly one counter increments.
//    FSM is back in ST_IDLE in that same cycle, so a frame starting right there is accepted.
//  - Counters saturate at all-ones; they do not wrap.
//  - i_stat_rx_status low in any state: abort the frame with no report, no count; go to ST_SYNC.
//  - tvalid low mid-frame: hold state, no timeout.
//  - Reset mid-frame: frame is lost, then ST_SYNC resynchronises on the next tlast.
// CONFIGURATION
//  AXIS_CHK_FIRST_ERR_EN defined: on the first header or payload mismatch after reset, latch the
//    beat index and swapped data into o_first_err_beat/o_first_err_data; they hold until reset.
//  Not defined: both outputs are tied to 0 and the capture registers are not built.
// STRUCTURE
//  - eth_test_frame_pkg (shared with the generator): P_RECV_LEN, MAC/TYPE constants,
//    err_code bit positions, FSM state encodings.
//  - One sub-module, axis_byte_swap64: combinational reversal of 64-bit data and 8-bit keep,
//    reused by the generator.
//  - The FSM, beat counter, expected-data mux and counters all live in this module.
// TESTING
//  - Link up, one drop frame, then 3 generator-format frames of 186 beats
//    -> 3 done pulses, ok=1, good_cnt=3, bad_cnt=0.
//  - Beat 50 payload word = 16'h0000 instead of 16'd49
//    -> err_code=4'b0010, bad_cnt+1; with macro, first_err_beat=50.
//  - tlast on beat 100 -> err_code=4'b0100. Frame of 190 beats -> ST_DROP, one report with
//    err_code=4'b0100 after beat 190.
//  - b0 DST byte 0x00 and tuser=1 on tlast -> err_code=4'b1001, good_cnt unchanged.
//  - i_stat_rx_status dropped at beat 80 -> no done pulse, counters unchanged; next full frame
//    is discarded (sync), following frame ok.
//  - Preload counter to 2^P_CNT_W-1, send good frame -> good_cnt stays all-ones.

Source files
------------

// File: rtl/eth_test_frame_pkg.sv
// Shared constants for the 10G Ethernet test-frame generator and checker:
// frame length, header fields, error-code bit positions and checker states.
package eth_test_frame_pkg;

    localparam int          P_RECV_LEN = 186;
    localparam logic [47:0] P_DST_MAC  = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [47:0] P_SRC_MAC  = 48'h01_02_03_04_05_06;
    localparam logic [15:0] P_TYPE     = 16'h0800;

    localparam int ERR_HDR  = 0;
    localparam int ERR_PAY  = 1;
    localparam int ERR_LEN  = 2;
    localparam int ERR_KEEP = 3;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_IDLE = 3'd1,
        ST_HDR  = 3'd2,
        ST_PAY  = 3'd3,
        ST_DROP = 3'd4
    } chk_state_t;

    // Beat n of a test frame after byte swap (first wire byte in [63:56]).
    function automatic logic [63:0] exp_beat(input logic [15:0] idx,
                                             input logic [47:0] dst,
                                             input logic [47:0] src,
                                             input logic [15:0] typ);
        logic [15:0] w;
        w = idx - 16'd1;
        if (idx == 16'd0)
            return {dst, src[47:32]};
        else if (idx == 16'd1)
            return {src[31:0], typ, 16'hffff};
        else
            return {w, w, w, w};
    endfunction

endpackage

// File: rtl/axis_byte_swap64.sv
// Combinational reversal of a 64-bit AXIS beat: bytes of data, bits of keep.
module axis_byte_swap64 (
    input  logic [63:0] data_in,
    input  logic [7:0]  keep_in,
    output logic [63:0] data_out,
    output logic [7:0]  keep_out
);

    for (genvar i = 0; i < 8; i++) begin : g_swap
        assign data_out[8*i +: 8] = data_in[8*(7-i) +: 8];
        assign keep_out[i]        = keep_in[7-i];
    end

endmodule

// File: rtl/axis_rx_frame_checker.sv
// Checks header and counting payload of test frames on the MAC RX AXIS stream.
// Define AXIS_CHK_FIRST_ERR_EN to capture the first mismatching beat index/data.
//
// state   | meaning
// ST_SYNC | discard beats until a tlast with link up
// ST_IDLE | waiting for beat 0 (destination/source MAC)
// ST_HDR  | expecting beat 1 (source MAC low, EtherType)
// ST_PAY  | counting payload beats 2..P_RECV_LEN-1
// ST_DROP | frame too long, discard until tlast
module axis_rx_frame_checker
    import eth_test_frame_pkg::*;
#(
    parameter int          P_RECV_LEN = eth_test_frame_pkg::P_RECV_LEN,
    parameter logic [47:0] P_DST_MAC  = eth_test_frame_pkg::P_DST_MAC,
    parameter logic [47:0] P_SRC_MAC  = eth_test_frame_pkg::P_SRC_MAC,
    parameter logic [15:0] P_TYPE     = eth_test_frame_pkg::P_TYPE,
    parameter int          P_CNT_W    = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stat_rx_status,
    input  logic               s_axis_rx_tvalid,
    input  logic [63:0]        s_axis_rx_tdata,
    input  logic               s_axis_rx_tlast,
    input  logic [7:0]         s_axis_rx_tkeep,
    input  logic               s_axis_rx_tuser,
    output logic               o_frame_done,
    output logic               o_frame_ok,
    output logic [3:0]         o_err_code,
    output logic [P_CNT_W-1:0] o_good_cnt,
    output logic [P_CNT_W-1:0] o_bad_cnt,
    output logic [15:0]        o_first_err_beat,
    output logic [63:0]        o_first_err_data
);

    localparam logic [15:0] LAST_IDX = 16'(P_RECV_LEN - 1);

    chk_state_t  state, state_nxt;
    logic [15:0] beat_cnt, beat_cnt_nxt;
    logic [3:0]  err_acc, err_acc_nxt, beat_err, frame_code;
    logic        frame_end;
    logic [63:0] d, exp_data;
    logic [7:0]  k;
    logic        data_mis;

    axis_byte_swap64 u_swap (
        .data_in  (s_axis_rx_tdata),
        .keep_in  (s_axis_rx_tkeep),
        .data_out (d),
        .keep_out (k)
    );

    assign exp_data   = exp_beat(beat_cnt, P_DST_MAC, P_SRC_MAC, P_TYPE);
    assign data_mis   = (d != exp_data);
    assign frame_code = err_acc | beat_err;

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        err_acc_nxt  = err_acc;
        beat_err     = '0;
        frame_end    = 1'b0;
        if (!i_stat_rx_status) begin
            state_nxt    = ST_SYNC;
            beat_cnt_nxt = '0;
            err_acc_nxt  = '0;
        end else if (s_axis_rx_tvalid) begin
            case (state)
                ST_SYNC: begin
                    if (s_axis_rx_tlast)
                        state_nxt = ST_IDLE;
                end
                ST_IDLE, ST_HDR: begin
                    beat_err[ERR_HDR] = data_mis;
                    if (s_axis_rx_tlast) begin
                        beat_err[ERR_LEN] = 1'b1;
                        frame_end         = 1'b1;
                    end else begin
                        state_nxt = (state == ST_IDLE) ? ST_HDR : ST_PAY;
                    end
                end
                ST_PAY: begin
                    beat_err[ERR_PAY] = data_mis;
                    if (beat_cnt == LAST_IDX) begin
                        if (s_axis_rx_tlast) begin
                            frame_end = 1'b1;
                        end else begin
                            beat_err[ERR_LEN] = 1'b1;
                            state_nxt         = ST_DROP;
                        end
                    end else if (s_axis_rx_tlast) begin
                        beat_err[ERR_LEN] = 1'b1;
                        frame_end         = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (s_axis_rx_tlast)
                        frame_end = 1'b1;
                end
                default: state_nxt = ST_SYNC;
            endcase
            if (state != ST_SYNC) begin
                beat_err[ERR_KEEP] = (k != 8'hff) || (s_axis_rx_tlast && s_axis_rx_tuser);
                beat_cnt_nxt       = beat_cnt + 16'd1;
                err_acc_nxt        = err_acc | beat_err;
            end
            if (frame_end) begin
                state_nxt    = ST_IDLE;
                beat_cnt_nxt = '0;
                err_acc_nxt  = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_SYNC;
            beat_cnt     <= '0;
            err_acc      <= '0;
            o_frame_done <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_err_code   <= '0;
            o_good_cnt   <= '0;
            o_bad_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            beat_cnt     <= beat_cnt_nxt;
            err_acc      <= err_acc_nxt;
            o_frame_done <= frame_end;
            if (frame_end) begin
                o_err_code <= frame_code;
                o_frame_ok <= (frame_code == 4'd0);
                // Counters stick at all-ones rather than wrapping.
                if (frame_code == 4'd0) begin
                    if (o_good_cnt != '1)
                        o_good_cnt <= o_good_cnt + P_CNT_W'(1);
                end else begin
                    if (o_bad_cnt != '1)
                        o_bad_cnt <= o_bad_cnt + P_CNT_W'(1);
                end
            end
        end
    end

`ifdef AXIS_CHK_FIRST_ERR_EN
    logic captured;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            captured         <= 1'b0;
            o_first_err_beat <= '0;
            o_first_err_data <= '0;
        end else if (!captured && (beat_err[ERR_HDR] || beat_err[ERR_PAY])) begin
            captured         <= 1'b1;
            o_first_err_beat <= beat_cnt;
            o_first_err_data <= d;
        end
    end
`else
    assign o_first_err_beat = '0;
    assign o_first_err_data = '0;
`endif

endmodule

// File: tb/tb_axis_rx_frame_checker.sv
// Directed bench for axis_rx_frame_checker; narrow counters (2 bits) make saturation reachable.
module tb_axis_rx_frame_checker;

    localparam int CW = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_stat_rx_status = 1'b0;
    logic          tvalid = 1'b0;
    logic [63:0]   tdata = '0;
    logic          tlast = 1'b0;
    logic [7:0]    tkeep = '0;
    logic          tuser = 1'b0;
    logic          o_frame_done, o_frame_ok;
    logic [3:0]    o_err_code;
    logic [CW-1:0] o_good_cnt, o_bad_cnt;
    logic [15:0]   o_first_err_beat;
    logic [63:0]   o_first_err_data;

    int n_assert = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int base;
    logic [3:0] last_code = '0;
    logic       last_ok = 1'b0;
    logic [15:0] exp_feb;
    logic [63:0] exp_fed;

    axis_rx_frame_checker #(.P_CNT_W(CW)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_stat_rx_status (i_stat_rx_status),
        .s_axis_rx_tvalid (tvalid),
        .s_axis_rx_tdata  (tdata),
        .s_axis_rx_tlast  (tlast),
        .s_axis_rx_tkeep  (tkeep),
        .s_axis_rx_tuser  (tuser),
        .o_frame_done     (o_frame_done),
        .o_frame_ok       (o_frame_ok),
        .o_err_code       (o_err_code),
        .o_good_cnt       (o_good_cnt),
        .o_bad_cnt        (o_bad_cnt),
        .o_first_err_beat (o_first_err_beat),
        .o_first_err_data (o_first_err_data)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_frame_done) begin
            done_seen = done_seen + 1;
            last_code = o_err_code;
            last_ok   = o_frame_ok;
        end
    end

    function automatic logic [63:0] exp_beat(input int n);
        logic [15:0] w;
        w = 16'(n - 1);
        if (n == 0)      return 64'hffff_ffff_ffff_0102;
        else if (n == 1) return 64'h0304_0506_0800_ffff;
        else             return {w, w, w, w};
    endfunction

    function automatic logic [63:0] swap64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_frame(input int len, input int bad_beat, input logic [63:0] bad_val,
                              input int keep_beat, input bit bad_user,
                              input int drop_beat, input int gap_beat);
        logic [63:0] d;
        for (int n = 0; n < len; n++) begin
            if (n == drop_beat) begin
                tvalid = 1'b0;
                i_stat_rx_status = 1'b0;
                repeat (2) begin @(posedge i_clk); #1; end
                i_stat_rx_status = 1'b1;
                return;
            end
            if (n == gap_beat) begin
                tvalid = 1'b0;
                repeat (3) begin @(posedge i_clk); #1; end
            end
            d = (n == bad_beat) ? bad_val : exp_beat(n);
            tvalid = 1'b1;
            tdata  = swap64(d);
            tkeep  = (n == keep_beat) ? 8'hfe : 8'hff;
            tlast  = (n == len - 1);
            tuser  = bad_user && (n == len - 1);
            @(posedge i_clk); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge i_clk);
    endtask

    task automatic chk_frame(input string tag, input int delta, input logic [3:0] code,
                             input logic ok, input int good, input int bad);
        chk({tag, "_done"}, 64'(done_seen - base), 64'(delta));
        if (delta > 0) begin
            chk({tag, "_code"}, 64'(last_code), 64'(code));
            chk({tag, "_ok"}, 64'(last_ok), 64'(ok));
        end
        chk({tag, "_good"}, 64'(o_good_cnt), 64'(good));
        chk({tag, "_bad"}, 64'(o_bad_cnt), 64'(bad));
    endtask

    initial begin
`ifdef AXIS_CHK_FIRST_ERR_EN
        exp_feb = 16'd50;
        exp_fed = 64'h0031_0031_0031_0000;
`else
        exp_feb = 16'd0;
        exp_fed = 64'd0;
`endif
        #12;
        chk("rst_done", 64'(o_frame_done), 64'd0);
        chk("rst_ok", 64'(o_frame_ok), 64'd0);
        chk("rst_code", 64'(o_err_code), 64'd0);
        chk("rst_good", 64'(o_good_cnt), 64'd0);
        chk("rst_bad", 64'(o_bad_cnt), 64'd0);
        chk("rst_feb", 64'(o_first_err_beat), 64'd0);
        chk("rst_fed", o_first_err_data, 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_stat_rx_status = 1'b1;

        base = done_seen;
        send_frame(186, -1, '0, -1, 1'b0, -1, -1);
        settle();
        chk("sync", 64'(done_seen - base), 64'd0);

        base = done_seen;
        send_frame(186, -1, '0, -1, 1'b0, -1, -1);
        send_frame(186, -1, '0, -1, 1'b0, -1, 10);
        send_frame(186, -1, '0, -1, 1'b0, -1, -1);
        settle();
        chk_frame("good3", 3, 4'b0000, 1'b1, 3, 0);
        chk("good3_feb", 64'(o_first_err_beat), 64'd0);

        base = done_seen;
        send_frame(186, 50, 64'h0031_0031_0031_0000, -1, 1'b0, -1, -1);
        settle();
        chk_frame("pay", 1, 4'b0010, 1'b0, 3, 1);
        chk("pay_feb", 64'(o_first_err_beat), 64'(exp_feb));
        chk("pay_fed", o_first_err_data, exp_fed);

        base = done_seen;
        send_frame(101, -1, '0, -1, 1'b0, -1, -1);
        settle();
        chk_frame("short", 1, 4'b0100, 1'b0, 3, 2);

        base = done_seen;
        send_frame(190, -1, '0, -1, 1'b0, -1, -1);
        settle();
        chk_frame("long", 1, 4'b0100, 1'b0, 3, 3);

        base = done_seen;
        send_frame(186, 0, 64'h00ff_ffff_ffff_0102, -1, 1'b1, -1, -1);
        settle();
        chk_frame("hdr_user", 1, 4'b1001, 1'b0, 3, 3);
        chk("hdr_feb_hold", 64'(o_first_err_beat), 64'(exp_feb));

        base = done_seen;
        send_frame(186, -1, '0, 20, 1'b0, -1, -1);
        settle();
        chk_frame("keep", 1, 4'b1000, 1'b0, 3, 3);

        base = done_seen;
        send_frame(186, -1, '0, -1, 1'b0, 80, -1);
        settle();
        chk_frame("linkdrop", 0, 4'b0000, 1'b0, 3, 3);
        send_frame(186, -1, '0, -1, 1'b0, -1, -1);
        settle();
        chk("resync", 64'(done_seen - base), 64'd0);
        send_frame(186, -1, '0, -1, 1'b0, -1, -1);
        settle();
        chk_frame("after_sync", 1, 4'b0000, 1'b1, 3, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
